// File: rtl/version_store_pkg.sv
// Shared types and sizes for the four-slot versioned store.
package version_store_pkg;

    localparam int unsigned VER_W     = 2;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2,
        FLUSH  = 2'd3
    } state_e;

endpackage

// File: rtl/version_store_slot.sv
// One store slot: valid flag, fixed version tag and data word with load/update/clear.
module version_store_slot
    import version_store_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SLOT_IDX = 0
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              load,
    input  logic              update,
    input  logic              clear,
    input  logic [DATA_W-1:0] wr_data,
    output logic              valid,
    output logic [VER_W-1:0]  version,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [VER_W-1:0]  version_q, version_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Invalid slots present version 0 and data 0, so clear zeroes everything.
    always_comb begin
        valid_d   = valid_q;
        version_d = version_q;
        data_d    = data_q;
        if (clear) begin
            valid_d   = 1'b0;
            version_d = '0;
            data_d    = '0;
        end else if (load) begin
            valid_d   = 1'b1;
            version_d = VER_W'(SLOT_IDX);
            data_d    = wr_data;
        end else if (update) begin
            data_d    = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q   <= 1'b0;
            version_q <= '0;
            data_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            version_q <= version_d;
            data_q    <= data_d;
        end
    end

    assign valid   = valid_q;
    assign version = version_q;
    assign data    = data_q;

endmodule

// File: rtl/version_store.sv
// Four-slot versioned data store feeding priorityRouter.
// Optional VERSION_STORE_VALID_EN adds the slotValid[3:0] output.
module version_store
    import version_store_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic              wrUpdate,
    input  logic [DATA_W-1:0] wrData,
    input  logic              flushReq,
    output logic              flushBusy,
    output logic [VER_W-1:0]  version0,
    output logic [VER_W-1:0]  version1,
    output logic [VER_W-1:0]  version2,
    output logic [VER_W-1:0]  version3,
    output logic [DATA_W-1:0] dataOut0,
    output logic [DATA_W-1:0] dataOut1,
    output logic [DATA_W-1:0] dataOut2,
    output logic [DATA_W-1:0] dataOut3,
    output logic [VER_W-1:0]  latestVersion,
`ifdef VERSION_STORE_VALID_EN
    output logic [NUM_SLOTS-1:0] slotValid,
`endif
    output logic [CNT_W-1:0]  count
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [VER_W-1:0]  latest_q, latest_d;
    logic [VER_W-1:0]  walk_q, walk_d;

    logic [NUM_SLOTS-1:0] slot_load, slot_upd, slot_clr, slot_valid;
    logic [VER_W-1:0]     slot_ver  [NUM_SLOTS];
    logic [DATA_W-1:0]    slot_data [NUM_SLOTS];
    logic                 accept;

    assign wrReady = (state_q == EMPTY) || (state_q == ACTIVE) ||
                     ((state_q == FULL) && wrUpdate);
    assign accept  = wrValid && wrReady;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        latest_d  = latest_q;
        walk_d    = walk_q;
        slot_load = '0;
        slot_upd  = '0;
        slot_clr  = '0;
        case (state_q)
            FLUSH: begin
                slot_clr[walk_q] = 1'b1;
                if (slot_valid[walk_q]) begin
                    count_d = count_q - 1'b1;
                end
                // Slots fill contiguously, so clearing the latest one empties the store.
                if (walk_q == latest_q) begin
                    latest_d = '0;
                end
                walk_d = walk_q + 1'b1;
                if (walk_q == VER_W'(NUM_SLOTS - 1)) begin
                    state_d = EMPTY;
                    count_d = '0;
                end
            end
            default: begin
                if (accept) begin
                    if (wrUpdate && (count_q != '0)) begin
                        slot_upd[latest_q] = 1'b1;
                    end else begin
                        slot_load[count_q[VER_W-1:0]] = 1'b1;
                        count_d  = count_q + 1'b1;
                        latest_d = count_q[VER_W-1:0];
                        state_d  = (count_d == CNT_W'(NUM_SLOTS)) ? FULL : ACTIVE;
                    end
                end
                // A write accepted alongside flushReq lands first; the walk clears it.
                if (flushReq) begin
                    state_d = FLUSH;
                    walk_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            latest_q <= '0;
            walk_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            latest_q <= latest_d;
            walk_q   <= walk_d;
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        version_store_slot #(
            .DATA_W   (DATA_W),
            .SLOT_IDX (k)
        ) u_slot (
            .clk     (clk),
            .rstN    (rstN),
            .load    (slot_load[k]),
            .update  (slot_upd[k]),
            .clear   (slot_clr[k]),
            .wr_data (wrData),
            .valid   (slot_valid[k]),
            .version (slot_ver[k]),
            .data    (slot_data[k])
        );
    end

    assign version0      = slot_ver[0];
    assign version1      = slot_ver[1];
    assign version2      = slot_ver[2];
    assign version3      = slot_ver[3];
    assign dataOut0      = slot_data[0];
    assign dataOut1      = slot_data[1];
    assign dataOut2      = slot_data[2];
    assign dataOut3      = slot_data[3];
    assign latestVersion = latest_q;
    assign count         = count_q;
    assign flushBusy     = (state_q == FLUSH);
`ifdef VERSION_STORE_VALID_EN
    assign slotValid     = slot_valid;
`endif

endmodule

// File: tb/tb_version_store.sv
// Self-checking bench for version_store: directed vector table, corner sequences, random vs queue model.
module tb_version_store;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        wrValid = 1'b0;
    logic        wrUpdate = 1'b0;
    logic        flushReq = 1'b0;
    logic [31:0] wrData = '0;
    logic        wrReady, flushBusy;
    logic [1:0]  version0, version1, version2, version3, latestVersion;
    logic [31:0] dataOut0, dataOut1, dataOut2, dataOut3;
    logic [2:0]  count;

    version_store #(.DATA_W(32)) dut (
        .clk(clk), .rstN(rstN), .wrValid(wrValid), .wrReady(wrReady),
        .wrUpdate(wrUpdate), .wrData(wrData), .flushReq(flushReq),
        .flushBusy(flushBusy),
        .version0(version0), .version1(version1), .version2(version2), .version3(version3),
        .dataOut0(dataOut0), .dataOut1(dataOut1), .dataOut2(dataOut2), .dataOut3(dataOut3),
        .latestVersion(latestVersion), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  ver_a  [4];
    logic [31:0] data_a [4];
    always_comb begin
        ver_a[0] = version0; ver_a[1] = version1; ver_a[2] = version2; ver_a[3] = version3;
        data_a[0] = dataOut0; data_a[1] = dataOut1; data_a[2] = dataOut2; data_a[3] = dataOut3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of stored words in version order, plus flush progress.
    logic [31:0] m_q[$];
    int          m_flush_left = 0;
    int          m_cleared    = 0;

    function automatic bit m_valid(input int k);
        return (k >= m_cleared) && (k < m_q.size());
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int k = 0; k < 4; k++) if (m_valid(k)) n++;
        return n;
    endfunction

    function automatic int m_latest();
        for (int k = 3; k >= 0; k--) if (m_valid(k)) return k;
        return 0;
    endfunction

    function automatic bit m_ready(input logic upd);
        return (m_flush_left == 0) && ((m_q.size() < 4) || upd);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_flush_left = 0;
        m_cleared    = 0;
    endtask

    task automatic m_step(input logic v, input logic u, input logic [31:0] d, input logic f);
        if (m_flush_left > 0) begin
            m_cleared++;
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_q.delete();
                m_cleared = 0;
            end
        end else begin
            if (v && m_ready(u)) begin
                if (u && m_q.size() > 0) m_q[m_q.size()-1] = d;
                else m_q.push_back(d);
            end
            if (f) begin
                m_flush_left = 4;
                m_cleared    = 0;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("version%0d", k), 32'(ver_a[k]), m_valid(k) ? 32'(k) : 32'd0);
            chk($sformatf("dataOut%0d", k), data_a[k], m_valid(k) ? m_q[k] : 32'd0);
        end
        chk("count", 32'(count), 32'(m_count()));
        chk("latestVersion", 32'(latestVersion), 32'(m_latest()));
        chk("flushBusy", 32'(flushBusy), 32'(m_flush_left > 0));
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic apply(input logic v, input logic u, input logic [31:0] d, input logic f);
        wrValid = v; wrUpdate = u; wrData = d; flushReq = f;
        #1;
        chk("wrReady", 32'(wrReady), 32'(m_ready(u)));
        @(posedge clk);
        m_step(v, u, d, f);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic        v, u, f;
        logic [31:0] d;
        logic        exp_ready;
        int          exp_cnt, exp_lat;
        logic        exp_busy;
        logic [31:0] exp_d0, exp_d3;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // fill, held fifth write, update, flush walk (with ignored mid-flush pulse), refill
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'hA0, 1'b1, 1, 0, 1'b0, 32'hA0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 2, 1, 1'b0, 32'hA0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'hA2, 1'b1, 3, 2, 1'b0, 32'hA0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'hA3, 1'b1, 4, 3, 1'b0, 32'hA0, 32'hA3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'hA4, 1'b0, 4, 3, 1'b0, 32'hA0, 32'hA3};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'hBB, 1'b1, 4, 3, 1'b0, 32'hA0, 32'hBB};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 4, 3, 1'b1, 32'hA0, 32'hBB};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 3, 3, 1'b1, 32'h0,  32'hBB};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 2, 3, 1'b1, 32'h0,  32'hBB};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1, 3, 1'b1, 32'h0,  32'hBB};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 0, 0, 1'b0, 32'h0,  32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 1, 0, 1'b0, 32'h55, 32'h0};

        // T1: reset values
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst count", 32'(count), 32'd0);
        chk("rst wrReady", 32'(wrReady), 32'd1);
        chk("rst flushBusy", 32'(flushBusy), 32'd0);
        check_model();
        rstN = 1'b1;
        @(negedge clk);

        // T2-T4 table
        for (int i = 0; i < 12; i++) begin
            wrValid = tbl[i].v; wrUpdate = tbl[i].u; wrData = tbl[i].d; flushReq = tbl[i].f;
            #1;
            chk($sformatf("vec%0d wrReady", i), 32'(wrReady), 32'(tbl[i].exp_ready));
            apply(tbl[i].v, tbl[i].u, tbl[i].d, tbl[i].f);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d latest", i), 32'(latestVersion), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d busy", i), 32'(flushBusy), 32'(tbl[i].exp_busy));
            chk($sformatf("vec%0d dataOut0", i), dataOut0, tbl[i].exp_d0);
            chk($sformatf("vec%0d dataOut3", i), dataOut3, tbl[i].exp_d3);
        end
        chk("refill version0", 32'(version0), 32'd0);

        // T6: async reset in flush cycle 2
        apply(1'b1, 1'b0, 32'h66, 1'b1);
        apply(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        m_reset();
        chk("t6 count", 32'(count), 32'd0);
        chk("t6 flushBusy", 32'(flushBusy), 32'd0);
        chk("t6 dataOut0", dataOut0, 32'd0);
        chk("t6 dataOut1", dataOut1, 32'd0);
        chk("t6 wrReady", 32'(wrReady), 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        apply(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6 post busy", 32'(flushBusy), 32'd0);

        // T5: write collides with flushReq; mid-flush pulse adds no cycles
        apply(1'b1, 1'b0, 32'hCC, 1'b1);
        chk("t5 hold", dataOut0, 32'hCC);
        chk("t5 busy", 32'(flushBusy), 32'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5 cleared", dataOut0, 32'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0);
        apply(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5 busy last", 32'(flushBusy), 32'd1);
        apply(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5 busy done", 32'(flushBusy), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  $urandom(), 1'($urandom_range(0, 15) == 0));
        end

        wrValid = 1'b0; wrUpdate = 1'b0; flushReq = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
